// File: rtl/dpi_pkg.sv
// dpi_pkg: shared definitions for the DPI stream sequencer slice.
//   SID_W / NUM_STREAMS : stream ID width and number of tracked streams
//   CHAR_W              : payload byte width
//   seq_state_t         : per-packet sequencer FSM states
package dpi_pkg;

  localparam int unsigned SID_W       = 6;
  localparam int unsigned NUM_STREAMS = 64;
  localparam int unsigned CHAR_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_STREAM,
    S_DRAIN,
    S_EOP
  } seq_state_t;

endpackage

// File: rtl/dpi_stream_table.sv
// dpi_stream_table: per-stream regex enable table plus per-stream seen bitmap.
//   clk, rst         : clock, synchronous active-high reset
//   cfg_wr/addr/wdata: enable-table write, visible from the next cycle
//   en_addr/en_data  : combinational enable-table read
//   seen_addr/seen_bit: combinational seen-bitmap read
//   clr_seen         : clears the whole bitmap
//   set_seen/set_addr: marks one stream as seen; wins over a same-cycle clear
module dpi_stream_table
  import dpi_pkg::*;
#(
  parameter int unsigned          NUM_REGEX = 16,
  parameter logic [NUM_REGEX-1:0] EN_RESET  = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_wr,
  input  logic [SID_W-1:0]     cfg_addr,
  input  logic [NUM_REGEX-1:0] cfg_wdata,
  input  logic [SID_W-1:0]     en_addr,
  output logic [NUM_REGEX-1:0] en_data,
  input  logic [SID_W-1:0]     seen_addr,
  output logic                 seen_bit,
  input  logic                 clr_seen,
  input  logic                 set_seen,
  input  logic [SID_W-1:0]     set_addr
);

  logic [NUM_REGEX-1:0]   en_tbl [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] seen;
  logic [NUM_STREAMS-1:0] seen_next;

  assign en_data  = en_tbl[en_addr];
  assign seen_bit = seen[seen_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STREAMS; i++) en_tbl[i] <= EN_RESET;
    end else if (cfg_wr) begin
      en_tbl[cfg_addr] <= cfg_wdata;
    end
  end

  // Clear is applied before set so a finishing stream stays marked.
  always_comb begin
    seen_next = clr_seen ? '0 : seen;
    if (set_seen) seen_next[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) seen <= '0;
    else     seen <= seen_next;
  end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer: per-packet controller driving the regex matcher bank.
//   Upstream : pkt_vld/pkt_sop/pkt_eop/pkt_data/pkt_sid in, pkt_rdy out
//   Config   : cfg_wr/cfg_addr/cfg_wdata (enable table), cfg_clr_seen
//   Matchers : load_state, new_stream_id, stream_id, char_in, char_in_vld,
//              eop, enable (all registered)
//   Status   : busy (FSM not idle)
// Optional macro DPI_SEQ_STATS_EN adds saturating stat_pkts, stat_bytes and
// stat_errs counters.
module dpi_stream_sequencer
  import dpi_pkg::*;
#(
  parameter int unsigned          NUM_REGEX    = 16,
  parameter int unsigned          DRAIN_CYCLES = 2,
  parameter logic [NUM_REGEX-1:0] EN_RESET     = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_vld,
  input  logic                 pkt_sop,
  input  logic                 pkt_eop,
  input  logic [CHAR_W-1:0]    pkt_data,
  input  logic [SID_W-1:0]     pkt_sid,
  output logic                 pkt_rdy,
  input  logic                 cfg_wr,
  input  logic [SID_W-1:0]     cfg_addr,
  input  logic [NUM_REGEX-1:0] cfg_wdata,
  input  logic                 cfg_clr_seen,
  output logic                 load_state,
  output logic                 new_stream_id,
  output logic [SID_W-1:0]     stream_id,
  output logic [CHAR_W-1:0]    char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  output logic [NUM_REGEX-1:0] enable,
  output logic                 busy
`ifdef DPI_SEQ_STATS_EN
  ,
  output logic [31:0]          stat_pkts,
  output logic [31:0]          stat_bytes,
  output logic [15:0]          stat_errs
`endif
);

  localparam logic [2:0] DRAIN_LEN = 3'(DRAIN_CYCLES);

  seq_state_t           state;
  logic                 got_beat;   // first (SOP) beat of this packet taken
  logic [2:0]           since_q;    // cycles since char_in_vld, saturating
  logic [2:0]           since_cur;
  logic                 stream_acc;
  logic                 sop_abort;
  logic                 seen_bit;
  logic [NUM_REGEX-1:0] tbl_en;

  // The SOP beat is left pending in IDLE and consumed as the first payload
  // byte in STREAM; any later SOP means the previous packet lost its EOP.
  always_comb begin
    pkt_rdy = 1'b0;
    case (state)
      S_IDLE:   pkt_rdy = pkt_vld & ~pkt_sop;
      S_STREAM: pkt_rdy = ~(got_beat & pkt_sop);
      default:  pkt_rdy = 1'b0;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign stream_acc = (state == S_STREAM) & pkt_vld & pkt_rdy;
  assign sop_abort  = (state == S_STREAM) & got_beat & pkt_vld & pkt_sop;
  assign since_cur  = char_in_vld ? 3'd0 : since_q;

  dpi_stream_table #(
    .NUM_REGEX (NUM_REGEX),
    .EN_RESET  (EN_RESET)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .en_addr   (stream_id),
    .en_data   (tbl_en),
    .seen_addr (pkt_sid),
    .seen_bit  (seen_bit),
    .clr_seen  (cfg_clr_seen),
    .set_seen  (state == S_EOP),
    .set_addr  (stream_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      got_beat      <= 1'b0;
      since_q       <= '1;
      load_state    <= 1'b0;
      new_stream_id <= 1'b0;
      stream_id     <= '0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      enable        <= '0;
    end else begin
      load_state    <= 1'b0;
      new_stream_id <= 1'b0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      since_q       <= char_in_vld ? 3'd1 : ((&since_q) ? since_q : since_q + 3'd1);
      case (state)
        S_IDLE: begin
          if (pkt_vld && pkt_sop) begin
            state         <= S_LOAD;
            stream_id     <= pkt_sid;
            load_state    <= 1'b1;
            new_stream_id <= ~seen_bit;
          end
        end
        S_LOAD: begin
          enable   <= tbl_en;
          got_beat <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: state <= S_STREAM;
        S_STREAM: begin
          if (stream_acc) begin
            char_in     <= pkt_data;
            char_in_vld <= 1'b1;
            got_beat    <= 1'b1;
            if (pkt_eop) state <= S_DRAIN;
          end else if (sop_abort) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (since_cur >= DRAIN_LEN) begin
            state <= S_EOP;
            eop   <= 1'b1;
          end
        end
        S_EOP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DPI_SEQ_STATS_EN
  logic idle_drop;
  assign idle_drop = (state == S_IDLE) & pkt_vld & ~pkt_sop;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts  <= '0;
      stat_bytes <= '0;
      stat_errs  <= '0;
    end else begin
      if (eop && (stat_pkts != '1))         stat_pkts  <= stat_pkts + 32'd1;
      if (char_in_vld && (stat_bytes != '1)) stat_bytes <= stat_bytes + 32'd1;
      if ((idle_drop || sop_abort) && (stat_errs != '1)) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb_dpi_stream_sequencer: directed table-driven bench for dpi_stream_sequencer
// (DRAIN_CYCLES = 2, NUM_REGEX = 16) plus event-log checks for multi-cycle cases.
module tb_dpi_stream_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_vld, pkt_sop, pkt_eop;
  logic [7:0]  pkt_data;
  logic [5:0]  pkt_sid;
  logic        pkt_rdy;
  logic        cfg_wr;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_clr_seen;
  logic        load_state, new_stream_id, char_in_vld, eop, busy;
  logic [5:0]  stream_id;
  logic [7:0]  char_in;
  logic [15:0] enable;
`ifdef DPI_SEQ_STATS_EN
  logic [31:0] stat_pkts, stat_bytes;
  logic [15:0] stat_errs;
`endif

  dpi_stream_sequencer #(
    .NUM_REGEX    (16),
    .DRAIN_CYCLES (2),
    .EN_RESET     (16'hFFFF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_vld       (pkt_vld),
    .pkt_sop       (pkt_sop),
    .pkt_eop       (pkt_eop),
    .pkt_data      (pkt_data),
    .pkt_sid       (pkt_sid),
    .pkt_rdy       (pkt_rdy),
    .cfg_wr        (cfg_wr),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_clr_seen  (cfg_clr_seen),
    .load_state    (load_state),
    .new_stream_id (new_stream_id),
    .stream_id     (stream_id),
    .char_in       (char_in),
    .char_in_vld   (char_in_vld),
    .eop           (eop),
    .enable        (enable),
    .busy          (busy)
`ifdef DPI_SEQ_STATS_EN
    ,
    .stat_pkts     (stat_pkts),
    .stat_bytes    (stat_bytes),
    .stat_errs     (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- event log ----------------
  typedef struct packed {
    logic [1:0]  kind;  // 0 load (val = new_stream_id), 1 char, 2 eop (val = enable)
    logic [5:0]  sid;
    logic [15:0] val;
  } ev_t;

  ev_t         ev_q[$];
  ev_t         exp_q[$];
  int unsigned excl_viol = 0;

  function automatic ev_t mk(input logic [1:0] k, input logic [5:0] s, input logic [15:0] v);
    ev_t e;
    e.kind = k; e.sid = s; e.val = v;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (load_state)  ev_q.push_back(mk(2'd0, stream_id, 16'(new_stream_id)));
    if (char_in_vld) ev_q.push_back(mk(2'd1, stream_id, 16'(char_in)));
    if (eop)         ev_q.push_back(mk(2'd2, stream_id, enable));
    if ((2'(load_state) + 2'(eop) + 2'(char_in_vld)) > 2'd1) excl_viol++;
  end

  task automatic compare_ev(input string name);
    check({name, " event count"}, 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      check($sformatf("%s event %0d", name, i), 32'(ev_q[i]), 32'(exp_q[i]));
    ev_q.delete();
    exp_q.delete();
  endtask

  // ---------------- beat driver ----------------
  typedef struct packed {
    logic       sop, eop;
    logic [7:0] data;
    logic [5:0] sid;
  } beat_t;

  beat_t bq[$];

  task automatic idle_inputs();
    pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = '0; pkt_sid = '0;
  endtask

  // Holds each beat until accepted, then waits for the FSM to return idle.
  task automatic send_beats(input string name);
    int unsigned guard;
    for (int i = 0; i < bq.size(); i++) begin
      @(negedge clk);
      pkt_vld = 1'b1; pkt_sop = bq[i].sop; pkt_eop = bq[i].eop;
      pkt_data = bq[i].data; pkt_sid = bq[i].sid;
      guard = 0;
      #1;
      while (!pkt_rdy && guard < 60) begin @(negedge clk); #1; guard++; end
      check($sformatf("%s beat %0d accepted", name, i), 32'(pkt_rdy), 32'd1);
      if (!pkt_rdy) break;
    end
    @(negedge clk);
    idle_inputs();
    guard = 0;
    while (busy && guard < 60) begin @(negedge clk); guard++; end
    check({name, " returns idle"}, 32'(busy), 32'd0);
    bq.delete();
  endtask

  // ---------------- cycle table ----------------
  // Inputs apply during cycle r; rdy is checked in cycle r, the registered
  // outputs are checked in cycle r+1.
  typedef struct {
    logic       vld, sop, eop;
    logic [7:0] data;
    logic [5:0] sid;
    logic       rdy;
    logic       ld, nsid, civ;
    logic [7:0] ch;
    logic       eopo, bsy;
  } row_t;

  localparam int NROWS = 21;
  row_t rows[NROWS];

  function automatic row_t R(input logic v, s, e, input logic [7:0] d, input logic [5:0] id,
                             input logic rd, l, n, c, input logic [7:0] ch, input logic eo, b);
    row_t r;
    r.vld = v; r.sop = s; r.eop = e; r.data = d; r.sid = id; r.rdy = rd;
    r.ld = l; r.nsid = n; r.civ = c; r.ch = ch; r.eopo = eo; r.bsy = b;
    return r;
  endfunction

  initial begin
    int unsigned guard;

    //              vld sop eop data   sid rdy ld nsid civ ch     eop busy
    rows[0]  = R(1, 0, 0, 8'h55, 6'd0, 1, 0, 0, 0, 8'h00, 0, 0);  // dropped beat
    rows[1]  = R(1, 1, 0, 8'h41, 6'd5, 0, 1, 1, 0, 8'h00, 0, 1);  // SOP sid 5
    rows[2]  = R(1, 1, 0, 8'h41, 6'd5, 0, 0, 0, 0, 8'h00, 0, 1);  // LOAD
    rows[3]  = R(1, 1, 0, 8'h41, 6'd5, 0, 0, 0, 0, 8'h00, 0, 1);  // WAIT
    rows[4]  = R(1, 1, 0, 8'h41, 6'd5, 1, 0, 0, 1, 8'h41, 0, 1);
    rows[5]  = R(1, 0, 0, 8'h42, 6'd5, 1, 0, 0, 1, 8'h42, 0, 1);
    rows[6]  = R(1, 0, 1, 8'h43, 6'd5, 1, 0, 0, 1, 8'h43, 0, 1);  // EOP beat
    rows[7]  = R(0, 0, 0, 8'h00, 6'd0, 0, 0, 0, 0, 8'h00, 0, 1);
    rows[8]  = R(0, 0, 0, 8'h00, 6'd0, 0, 0, 0, 0, 8'h00, 0, 1);
    rows[9]  = R(0, 0, 0, 8'h00, 6'd0, 0, 0, 0, 0, 8'h00, 1, 1);  // eop = E+4
    rows[10] = R(0, 0, 0, 8'h00, 6'd0, 0, 0, 0, 0, 8'h00, 0, 0);
    rows[11] = R(1, 1, 0, 8'h10, 6'd5, 0, 1, 0, 0, 8'h00, 0, 1);  // sid 5 again
    rows[12] = R(1, 1, 0, 8'h10, 6'd5, 0, 0, 0, 0, 8'h00, 0, 1);
    rows[13] = R(1, 1, 0, 8'h10, 6'd5, 0, 0, 0, 0, 8'h00, 0, 1);
    rows[14] = R(1, 1, 0, 8'h10, 6'd5, 1, 0, 0, 1, 8'h10, 0, 1);
    rows[15] = R(0, 0, 0, 8'h00, 6'd5, 1, 0, 0, 0, 8'h00, 0, 1);  // gap
    rows[16] = R(1, 0, 1, 8'h11, 6'd5, 1, 0, 0, 1, 8'h11, 0, 1);
    rows[17] = R(0, 0, 0, 8'h00, 6'd0, 0, 0, 0, 0, 8'h00, 0, 1);
    rows[18] = R(0, 0, 0, 8'h00, 6'd0, 0, 0, 0, 0, 8'h00, 0, 1);
    rows[19] = R(0, 0, 0, 8'h00, 6'd0, 0, 0, 0, 0, 8'h00, 1, 1);
    rows[20] = R(0, 0, 0, 8'h00, 6'd0, 0, 0, 0, 0, 8'h00, 0, 0);

    rst = 1'b1;
    idle_inputs();
    cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_clr_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset load_state",    32'(load_state),    0);
    check("reset new_stream_id", 32'(new_stream_id), 0);
    check("reset stream_id",     32'(stream_id),     0);
    check("reset char_in",       32'(char_in),       0);
    check("reset char_in_vld",   32'(char_in_vld),   0);
    check("reset eop",           32'(eop),           0);
    check("reset enable",        32'(enable),        0);
    check("reset busy",          32'(busy),          0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NROWS; i++) begin
      @(negedge clk);
      pkt_vld = rows[i].vld; pkt_sop = rows[i].sop; pkt_eop = rows[i].eop;
      pkt_data = rows[i].data; pkt_sid = rows[i].sid;
      #1;
      check($sformatf("row%0d pkt_rdy", i), 32'(pkt_rdy), 32'(rows[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("row%0d load_state", i),  32'(load_state),  32'(rows[i].ld));
      check($sformatf("row%0d char_in_vld", i), 32'(char_in_vld), 32'(rows[i].civ));
      check($sformatf("row%0d eop", i),         32'(eop),         32'(rows[i].eopo));
      check($sformatf("row%0d busy", i),        32'(busy),        32'(rows[i].bsy));
      if (rows[i].ld) begin
        check($sformatf("row%0d new_stream_id", i), 32'(new_stream_id), 32'(rows[i].nsid));
        check($sformatf("row%0d stream_id", i),     32'(stream_id),     32'd5);
      end
      if (rows[i].civ)  check($sformatf("row%0d char_in", i), 32'(char_in), 32'(rows[i].ch));
      if (rows[i].eopo) check($sformatf("row%0d enable", i),  32'(enable),  32'hFFFF);
    end
    @(negedge clk);
    idle_inputs();
    ev_q.delete();

    // A: clearing the seen bitmap makes sid 5 new again
    @(negedge clk); cfg_clr_seen = 1'b1;
    @(negedge clk); cfg_clr_seen = 1'b0;
    bq.push_back('{1'b1, 1'b0, 8'h50, 6'd5});
    bq.push_back('{1'b0, 1'b1, 8'h51, 6'd5});
    send_beats("A");
    exp_q.push_back(mk(0, 5, 16'd1)); exp_q.push_back(mk(1, 5, 16'h50));
    exp_q.push_back(mk(1, 5, 16'h51)); exp_q.push_back(mk(2, 5, 16'hFFFF));
    compare_ev("A clr_seen");

    // B: programmed enable mask for sid 9, single-beat packet
    @(negedge clk); cfg_wr = 1'b1; cfg_addr = 6'd9; cfg_wdata = 16'h0003;
    @(negedge clk); cfg_wr = 1'b0;
    bq.push_back('{1'b1, 1'b1, 8'h90, 6'd9});
    send_beats("B");
    exp_q.push_back(mk(0, 9, 16'd1)); exp_q.push_back(mk(1, 9, 16'h90));
    exp_q.push_back(mk(2, 9, 16'h0003));
    compare_ev("B cfg_wr");

    // C: table write after LOAD does not disturb the latched mask
    bq.push_back('{1'b1, 1'b0, 8'h91, 6'd9});
    bq.push_back('{1'b0, 1'b1, 8'h92, 6'd9});
    fork
      send_beats("C");
      begin
        guard = 0;
        @(posedge clk); #1;
        while (!load_state && guard < 60) begin @(posedge clk); #1; guard++; end
        check("C load seen", 32'(load_state), 32'd1);
        @(negedge clk); cfg_wr = 1'b1; cfg_addr = 6'd9; cfg_wdata = 16'h0000;
        @(negedge clk); cfg_wr = 1'b0;
      end
    join
    exp_q.push_back(mk(0, 9, 16'd0)); exp_q.push_back(mk(1, 9, 16'h91));
    exp_q.push_back(mk(1, 9, 16'h92)); exp_q.push_back(mk(2, 9, 16'h0003));
    compare_ev("C late write");

    // D: the late write applies to the following packet
    bq.push_back('{1'b1, 1'b1, 8'h93, 6'd9});
    send_beats("D");
    exp_q.push_back(mk(0, 9, 16'd0)); exp_q.push_back(mk(1, 9, 16'h93));
    exp_q.push_back(mk(2, 9, 16'h0000));
    compare_ev("D new mask");

    // E: SOP for sid 3 arrives before sid 1 saw its EOP
    bq.push_back('{1'b1, 1'b0, 8'h21, 6'd1});
    bq.push_back('{1'b0, 1'b0, 8'h22, 6'd1});
    bq.push_back('{1'b1, 1'b1, 8'h30, 6'd3});
    send_beats("E");
    exp_q.push_back(mk(0, 1, 16'd1));    exp_q.push_back(mk(1, 1, 16'h21));
    exp_q.push_back(mk(1, 1, 16'h22));   exp_q.push_back(mk(2, 1, 16'hFFFF));
    exp_q.push_back(mk(0, 3, 16'd1));    exp_q.push_back(mk(1, 3, 16'h30));
    exp_q.push_back(mk(2, 3, 16'hFFFF));
    compare_ev("E missing eop");
`ifdef DPI_SEQ_STATS_EN
    check("stat_errs",  32'(stat_errs), 32'd2);
    check("stat_pkts",  stat_pkts,      32'd8);
    check("stat_bytes", stat_bytes,     32'd14);
`endif

    // F: reset while streaming aborts without eop
    @(negedge clk);
    pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b0; pkt_sid = 6'd7; pkt_data = 8'h70;
    guard = 0;
    #1;
    while (!pkt_rdy && guard < 60) begin @(negedge clk); #1; guard++; end
    check("F first beat accepted", 32'(pkt_rdy), 32'd1);
    @(negedge clk);
    pkt_sop = 1'b0; pkt_data = 8'h71; rst = 1'b1;
    @(posedge clk); #1;
    check("F load_state",    32'(load_state),    0);
    check("F new_stream_id", 32'(new_stream_id), 0);
    check("F stream_id",     32'(stream_id),     0);
    check("F char_in",       32'(char_in),       0);
    check("F char_in_vld",   32'(char_in_vld),   0);
    check("F eop",           32'(eop),           0);
    check("F enable",        32'(enable),        0);
    check("F busy",          32'(busy),          0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (12) @(negedge clk);
    exp_q.push_back(mk(0, 7, 16'd1)); exp_q.push_back(mk(1, 7, 16'h70));
    compare_ev("F reset abort");

    // G: reset cleared the seen bitmap and restored the enable table
    bq.push_back('{1'b1, 1'b1, 8'hA0, 6'd5});
    bq.push_back('{1'b1, 1'b1, 8'hA1, 6'd9});
    send_beats("G");
    exp_q.push_back(mk(0, 5, 16'd1)); exp_q.push_back(mk(1, 5, 16'hA0));
    exp_q.push_back(mk(2, 5, 16'hFFFF));
    exp_q.push_back(mk(0, 9, 16'd1)); exp_q.push_back(mk(1, 9, 16'hA1));
    exp_q.push_back(mk(2, 9, 16'hFFFF));
    compare_ev("G post reset");

    check("strobe exclusivity violations", 32'(excl_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dpi_stream_sequencer.md
# dpi_stream_sequencer

Per-packet controller for the bank of stream-stateful regex matcher wrappers in the DPI core. It accepts a byte-wide packet stream tagged with a 6-bit stream ID and drives the matchers' shared sequencing bus: `load_state` / `new_stream_id` / `stream_id` at packet start, `char_in` / `char_in_vld` during the payload, and `eop` / `enable` at packet end. It also owns the per-stream "seen" bitmap and the per-stream regex enable table.

## Interface
Parameters:
- NUM_REGEX, 16, number of matcher wrappers; width of `enable`
- DRAIN_CYCLES, 2, idle cycles after the last `char_in_vld` before `eop`, covering matcher accept latency; range 1..7
- EN_RESET, all ones, reset value of every enable-table entry

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pkt_vld  in  1  upstream beat valid
- pkt_sop  in  1  first beat of packet
- pkt_eop  in  1  last beat of packet
- pkt_data  in  8  payload byte
- pkt_sid  in  6  stream ID; sampled on the SOP beat only
- pkt_rdy  out  1  beat accepted when `pkt_vld & pkt_rdy`
- cfg_wr  in  1  enable-table write strobe
- cfg_addr  in  6  enable-table entry
- cfg_wdata  in  NUM_REGEX  enable mask to write
- cfg_clr_seen  in  1  clears the whole seen bitmap
- load_state  out  1  one-cycle restore pulse to the matchers
- new_stream_id  out  1  stream not in the seen bitmap; valid with `load_state`
- stream_id  out  6  current stream; stable from LOAD until EOP
- char_in  out  8  byte to the matchers
- char_in_vld  out  1  `char_in` valid
- eop  out  1  one-cycle finalize pulse
- enable  out  NUM_REGEX  per-regex enable; valid with `eop`
- busy  out  1  FSM is not in IDLE

## Operation
FSM states: IDLE, LOAD, WAIT, STREAM, DRAIN, EOP.
- **IDLE**
  - `pkt_rdy` = `pkt_vld & ~pkt_sop`: non-SOP beats are dropped.
  - On `pkt_vld & pkt_sop`: latch `pkt_sid`, go to LOAD. The SOP beat is not consumed.
- **LOAD**
  - `load_state` = 1 and `new_stream_id` = `~seen[sid]`.
  - Latch `enable_tbl[sid]` into the enable register.
  - Go to WAIT.
- **WAIT**: one cycle for the matcher state restore. Go to STREAM.
- **STREAM**
  - `pkt_rdy` = 1.
  - Each accepted beat is registered: `char_in` = `pkt_data` and `char_in_vld` = 1 on the next cycle. Otherwise `char_in_vld` = 0.
  - Accepted beat with `pkt_eop`: go to DRAIN.
  - `pkt_vld & pkt_sop` seen while in STREAM (missing EOP):
    - The SOP beat is not accepted.
    - Go to DRAIN, which terminates the current packet.
    - The pending SOP is handled again from IDLE.
- **DRAIN**: count DRAIN_CYCLES cycles, starting after the last `char_in_vld`, then go to EOP.
- **EOP**
  - `eop` = 1 and `enable` = latched mask.
  - Set `seen[sid]`.
  - Go to IDLE.

Tables and bitmap:
- Enable table: 64 × NUM_REGEX flops.
  - A `cfg_wr` write takes effect the next cycle.
  - A packet already past LOAD keeps its latched mask.
- Seen bitmap: 64 flops.
  - `cfg_clr_seen` and the EOP set in the same cycle: clear first, then set, so `seen[sid]` ends at 1.

## Timing
- SOP presented at cycle T (in IDLE):
  - `load_state` at T+1.
  - `pkt_rdy` first high at T+3.
  - First `char_in_vld` at T+4 at the earliest.
- EOP beat accepted at cycle E: `eop` at E+1+DRAIN_CYCLES+1.
- Minimum gap: `load_state` of the next packet at the earliest 2 cycles after `eop`.
- `load_state`, `eop` and `char_in_vld` are mutually exclusive in every cycle.
- All outputs are registered except `pkt_rdy` and `busy`, which decode the state.
- Reset values:
  - FSM in IDLE.
  - All 1-bit outputs 0; `char_in`, `stream_id` and `enable` 0.
  - Seen bitmap all 0; enable table all EN_RESET.
- Reset mid-packet: abort with no `eop`. The matchers see no finalize.

## Configuration
- `DPI_SEQ_STATS_EN` defined adds three outputs; undefined, the outputs are absent and there is no counter logic:
  - `stat_pkts[31:0]`: +1 per `eop`.
  - `stat_bytes[31:0]`: +1 per `char_in_vld`.
  - `stat_errs[15:0]`: +1 per dropped IDLE beat and per missing-EOP termination.
- All counters saturate and reset to 0.

## Structure
- Shared package `dpi_pkg` holds:
  - `SID_W` = 6 and `NUM_STREAMS` = 64.
  - The FSM state enum.
  - `CHAR_W` = 8.
- Sub-module `dpi_stream_table`: 64-entry enable table plus seen bitmap, with the write, clear and set ports and the same-cycle ordering rule.

## Test plan
- Reset, then a 3-byte packet on sid 5 (0x41, 0x42, 0x43):
  - `load_state` with `new_stream_id` = 1 and `stream_id` = 5.
  - Three `char_in_vld` beats, in order.
  - `eop` exactly DRAIN_CYCLES+2 cycles after the EOP beat.
  - `enable` = 0xFFFF.
- Second packet on sid 5 → `new_stream_id` = 0. Then pulse `cfg_clr_seen`; a third packet on sid 5 → `new_stream_id` = 1.
- `cfg_wr` addr 9 data 0x0003, then a packet on sid 9 → `enable` = 0x0003 at `eop`. A write of 0x0000 to addr 9 after LOAD still yields 0x0003.
- Gaps (`pkt_vld` low) mid-packet → `char_in_vld` low in matching cycles; `eop` delayed accordingly.
- SOP on sid 3 arrives mid-packet for sid 1:
  - sid 1 is terminated with `eop`.
  - The sid 3 packet follows with its own `load_state`.
  - `stat_errs` = 1 with `DPI_SEQ_STATS_EN`.
- Assert `rst` while in STREAM:
  - No `eop`; all outputs 0 next cycle.
  - `busy` = 0 and the seen bitmap cleared.
